// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and sequencer in front of a
// single-ported data memory. Each transaction runs IDLE -> ACCESS -> DONE.
// The memory is driven only during ACCESS, and the requester is acked in DONE.
module dmem_arbiter #(
  parameter int MEM_WORDS = 64,
  parameter int AW        = 8,
  parameter int DW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic          a_err,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic          b_err,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_read_data,
  output logic          MemRead,
  output logic          MemWrite,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // One extra bit so that MEM_WORDS == 2**AW still compares correctly.
  localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(MEM_WORDS);

  state_t          state, state_nxt;
  logic            last_grant;  // 0 = A, 1 = B
  logic            grant;
  logic            grant_sel;   // 0 = A, 1 = B
  logic            sel_p0;
  logic            err_p0;
  logic            we_p0;
  logic [AW-1:0]   addr_p0;
  logic [DW-1:0]   wdata_p0;

  function automatic logic addr_illegal(input logic [AW-1:0] addr);
    return {1'b0, addr} >= ADDR_LIMIT;
  endfunction

  assign grant = (state == IDLE) && (a_req || b_req);

  // Arbitration: a single requester wins outright; on a tie the port not granted last time wins.
  always_comb begin
    grant_sel = 1'b0;
    if (a_req && b_req) begin
      grant_sel = ~last_grant;
    end else if (b_req) begin
      grant_sel = 1'b1;
    end
  end

  // State register; async reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control latched at the grant edge: selected port, fairness pointer, address error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_p0     <= 1'b0;
      last_grant <= 1'b1;
      err_p0     <= 1'b0;
    end else if (grant) begin
      sel_p0     <= grant_sel;
      last_grant <= grant_sel;
      err_p0     <= addr_illegal(grant_sel ? b_addr : a_addr);
    end
  end

  // Grant stage: capture the granted request so requester inputs are free afterwards.
  always_ff @(posedge clk) begin
    if (grant) begin
      we_p0    <= grant_sel ? b_we    : a_we;
      addr_p0  <= grant_sel ? b_addr  : a_addr;
      wdata_p0 <= grant_sel ? b_wdata : a_wdata;
    end
  end

  // Next state plus memory strobes and acks, all decoded from registered state.
  always_comb begin
    state_nxt      = state;
    mem_addr       = '0;
    mem_write_data = '0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    a_ack          = 1'b0;
    b_ack          = 1'b0;
    a_err          = 1'b0;
    b_err          = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        if (a_req || b_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt = DONE;
        if (!err_p0) begin
          mem_addr = addr_p0;
          MemRead  = ~we_p0;
          MemWrite = we_p0;
          if (we_p0) mem_write_data = wdata_p0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        a_ack     = ~sel_p0;
        b_ack     = sel_p0;
        a_err     = ~sel_p0 & err_p0;
        b_err     = sel_p0 & err_p0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Access stage: read data (or zero on error) lands in the selected port's rdata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (state == ACCESS) begin
      if (err_p0) begin
        if (sel_p0) b_rdata <= '0;
        else        a_rdata <= '0;
      end else if (!we_p0) begin
        if (sel_p0) b_rdata <= mem_read_data;
        else        a_rdata <= mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: scoreboard queues fed by a reference model,
// with a separate monitor that pops and compares on every ack.
module tb_dmem_arbiter;
  localparam int MEM_WORDS = 64;
  localparam int AW        = 8;
  localparam int DW        = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_ack, a_err;
  logic [DW-1:0] a_rdata;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_ack, b_err;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;
  logic          MemRead, MemWrite, busy;

  dmem_arbiter #(.MEM_WORDS(MEM_WORDS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: zero after power-up, idle read value 0x00FF00FF.
  logic [DW-1:0] tb_mem [MEM_WORDS] = '{default: '0};
  always @(posedge clk)
    if (MemWrite && mem_addr < 8'(MEM_WORDS)) tb_mem[mem_addr[5:0]] <= mem_write_data;
  assign mem_read_data = MemRead ? tb_mem[mem_addr[5:0]] : 32'h00FF00FF;

  // Reference model state and scoreboard.
  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  logic [DW-1:0] ref_mem [MEM_WORDS] = '{default: '0};
  logic [DW-1:0] ref_rd  [2] = '{default: '0};
  exp_t          qa[$], qb[$];
  int            ack_log[$], ack_cyc[$];
  int            nchk = 0, nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model(input bit p, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, output exp_t e);
    if (int'(addr) >= MEM_WORDS) begin
      e.err = 1'b1; e.rdata = '0;
    end else if (we) begin
      ref_mem[addr[5:0]] = wd;
      e.err = 1'b0; e.rdata = ref_rd[p];
    end else begin
      e.err = 1'b0; e.rdata = ref_mem[addr[5:0]];
    end
    ref_rd[p] = e.rdata;
  endtask

  task automatic issue(input bit p, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input int gap, input bit chk_lat,
                       input bit scr);
    exp_t e;
    int   t0;
    bit   got;
    repeat (gap) @(negedge clk);
    model(p, we, addr, wd, e);
    if (p) begin
      qb.push_back(e);
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      qa.push_back(e);
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    t0 = cyc;
    if (scr) begin
      @(posedge clk); #1;
      check("access_mem_addr", 32'(mem_addr), 32'(addr));
      check("access_memwrite", 32'(MemWrite), 32'(we));
      check("access_memread", 32'(MemRead), 32'(!we));
      check("access_wdata", mem_write_data, we ? wd : 32'h0);
      if (p) begin b_addr = 8'($urandom); b_wdata = $urandom; b_we = ~we; end
      else   begin a_addr = 8'($urandom); a_wdata = $urandom; a_we = ~we; end
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (p ? b_ack : a_ack) got = 1'b1;
    end
    if (!got) begin
      nchk++; nfail++;
      $display("FAIL ack_timeout port %0d: got no ack, required ack within 40 cycles", p);
    end else if (chk_lat) begin
      check("ack_latency", 32'(cyc - t0), 32'd2);
    end
    if (p) b_req = 1'b0;
    else   a_req = 1'b0;
  endtask

  // Monitor: pops expected responses on acks and polices idle outputs and strobes.
  task automatic monitor();
    logic [DW-1:0] hold [2];
    logic          ack [2], err [2];
    logic [DW-1:0] rd  [2];
    exp_t          e;
    hold[0] = '0; hold[1] = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold[0] = '0; hold[1] = '0;
        continue;
      end
      ack[0] = a_ack; err[0] = a_err; rd[0] = a_rdata;
      ack[1] = b_ack; err[1] = b_err; rd[1] = b_rdata;
      for (int p = 0; p < 2; p++) begin
        if (ack[p]) begin
          if ((p == 0 && qa.size() == 0) || (p == 1 && qb.size() == 0)) begin
            nchk++; nfail++;
            $display("FAIL unexpected_ack port %0d: got ack, required none", p);
          end else begin
            e = (p == 1) ? qb.pop_front() : qa.pop_front();
            check(p ? "b_err" : "a_err", 32'(err[p]), 32'(e.err));
            check(p ? "b_rdata" : "a_rdata", rd[p], e.rdata);
            hold[p] = e.rdata;
            ack_log.push_back(p);
            ack_cyc.push_back(cyc);
          end
        end else begin
          check(p ? "b_rdata_hold" : "a_rdata_hold", rd[p], hold[p]);
          check(p ? "b_err_idle" : "a_err_idle", 32'(err[p]), 32'd0);
        end
      end
      if (MemRead || MemWrite) begin
        check("strobe_addr_legal", 32'(mem_addr < 8'(MEM_WORDS)), 32'd1);
        check("strobe_exclusive", 32'(MemRead && MemWrite), 32'd0);
        check("strobe_busy", 32'(busy), 32'd1);
      end else begin
        check("idle_mem_addr", 32'(mem_addr), 32'd0);
        check("idle_mem_wdata", mem_write_data, 32'd0);
      end
    end
  endtask

  initial begin
    int t0;
    int exp_order [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", 32'({a_ack, b_ack, a_err, b_err}), 32'd0);
    check("rst_strobes", 32'({MemRead, MemWrite}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    fork
      monitor();
      begin
        // Simultaneous reads after reset, both held: A first, then alternating.
        ack_log.delete(); ack_cyc.delete();
        t0 = cyc;
        fork
          for (int k = 0; k < 4; k++) issue(1'b0, 1'b0, 8'd12, 32'h0, 0, 1'b0, 1'b0);
          for (int k = 0; k < 4; k++) issue(1'b1, 1'b0, 8'd13, 32'h0, 0, 1'b0, 1'b0);
        join
        check("tie_log_size", 32'(ack_log.size()), 32'd8);
        if (ack_log.size() == 8) begin
          for (int k = 0; k < 8; k++) check("tie_order", 32'(ack_log[k]), 32'(exp_order[k]));
          check("tie_a_ack_cycle", 32'(ack_cyc[0] - t0), 32'd2);
          check("tie_b_ack_cycle", 32'(ack_cyc[1] - t0), 32'd5);
        end

        // Unwritten legal address reads zero, never the idle bus value.
        issue(1'b0, 1'b0, 8'd10, 32'h0, 1, 1'b1, 1'b0);

        // A write, inputs scrambled during ACCESS; B reads it back.
        issue(1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 1, 1'b1, 1'b1);
        issue(1'b1, 1'b0, 8'h05, 32'h0, 1, 1'b1, 1'b0);

        // Out-of-range accesses: error ack, memory untouched.
        issue(1'b1, 1'b0, 8'h40, 32'h0, 1, 1'b1, 1'b0);
        issue(1'b1, 1'b1, 8'hFF, 32'hA5A5A5A5, 1, 1'b1, 1'b0);
        issue(1'b0, 1'b0, 8'd63, 32'h0, 1, 1'b1, 1'b0);
        issue(1'b1, 1'b1, 8'd63, 32'h12345678, 1, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 8'd63, 32'h0, 1, 1'b1, 1'b0);

        // Reset asserted mid-ACCESS of a write: no commit, no ack.
        issue(1'b0, 1'b1, 8'd3, 32'h11111111, 1, 1'b1, 1'b0);
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'd3; a_wdata = 32'h22222222;
        @(posedge clk);
        @(negedge clk);
        check("abort_memwrite_before", 32'(MemWrite), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("abort_memwrite_after", 32'(MemWrite), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        a_req = 1'b0;
        ref_rd[0] = '0; ref_rd[1] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy_released", 32'(busy), 32'd0);
        issue(1'b0, 1'b0, 8'd3, 32'h0, 1, 1'b1, 1'b0);

        // Random traffic: A owns even words, B odd words, both share illegal space.
        fork
          for (int k = 0; k < 60; k++)
            issue(1'b0, 1'($urandom), ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255))
                  : 8'($urandom_range(0, 31) * 2), $urandom, $urandom_range(0, 3), 1'b0, 1'b0);
          for (int k = 0; k < 60; k++)
            issue(1'b1, 1'($urandom), ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255))
                  : 8'($urandom_range(0, 31) * 2 + 1), $urandom, $urandom_range(0, 3), 1'b0, 1'b0);
        join
        repeat (4) @(negedge clk);
        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
